// File: rtl/outencode.sv
// Result-return path: pending slot per unit, fixed-priority arbiter, tagged show-ahead FIFO.
// Optional macro OUTENCODE_FP_FLAGS_EN adds result_flags = {is_nan, is_inf, is_zero}.
module outencode #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_MARGIN = 3
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     add_done,
    input  logic [31:0]              add_result,
    input  logic                     mul_done,
    input  logic [31:0]              mul_result,
    input  logic                     sine_done,
    input  logic [31:0]              sine_result,
    input  logic                     result_read,
    output logic                     result_valid,
    output logic [31:0]              result_data,
    output logic [2:0]               result_opcode,
    output logic [$clog2(DEPTH):0]   result_count,
    output logic                     out_fifo_hold,
    output logic                     overflow_err
`ifdef OUTENCODE_FP_FLAGS_EN
    ,
    output logic [2:0]               result_flags
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef OUTENCODE_FP_FLAGS_EN
    localparam int unsigned EW = 38;
`else
    localparam int unsigned EW = 35;
`endif

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_SINE = 3'b101;

    logic [2:0]    slot_v_q, slot_v_d;
    logic [31:0]   slot_data_q [3];
    logic [31:0]   slot_data_d [3];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic [2:0]    done_vec;
    logic [31:0]   res_vec [3];
    logic [2:0]    grant;
    logic          pop, push, push_ok;
    logic [31:0]   push_data;
    logic [2:0]    push_op;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;

`ifdef OUTENCODE_FP_FLAGS_EN
    function automatic logic [2:0] classify(input logic [31:0] v);
        logic exp_ones, exp_zero, man_zero;
        exp_ones = (v[30:23] == 8'hFF);
        exp_zero = (v[30:23] == 8'h00);
        man_zero = (v[22:0] == 23'd0);
        return {exp_ones && !man_zero, exp_ones && man_zero, exp_zero && man_zero};
    endfunction
`endif

    always_comb begin
        done_vec   = {sine_done, mul_done, add_done};
        res_vec[0] = add_result;
        res_vec[1] = mul_result;
        res_vec[2] = sine_result;

        pop     = result_read && (count_q != '0);
        push_ok = (count_q < CW'(DEPTH)) || pop;

        grant = 3'b000;
        if (slot_v_q[0])      grant = 3'b001;
        else if (slot_v_q[1]) grant = 3'b010;
        else if (slot_v_q[2]) grant = 3'b100;
        push = push_ok && (grant != 3'b000);

        push_data = '0;
        push_op   = '0;
        unique case (grant)
            3'b001:  begin push_data = slot_data_q[0]; push_op = OP_ADD;  end
            3'b010:  begin push_data = slot_data_q[1]; push_op = OP_MUL;  end
            3'b100:  begin push_data = slot_data_q[2]; push_op = OP_SINE; end
            default: begin push_data = '0;             push_op = '0;      end
        endcase
`ifdef OUTENCODE_FP_FLAGS_EN
        push_entry = {classify(push_data), push_op, push_data};
`else
        push_entry = {push_op, push_data};
`endif

        // A slot that drains this cycle may reload; otherwise a new done is lost.
        overflow_d = overflow_q;
        for (int i = 0; i < 3; i++) begin
            logic still_v;
            still_v        = slot_v_q[i] && !(push && grant[i]);
            slot_v_d[i]    = still_v || done_vec[i];
            slot_data_d[i] = (done_vec[i] && !still_v) ? res_vec[i] : slot_data_q[i];
            if (done_vec[i] && still_v) overflow_d = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            slot_v_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 3; i++) slot_data_q[i] <= '0;
        end else begin
            slot_v_q   <= slot_v_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < 3; i++) slot_data_q[i] <= slot_data_d[i];
        end
    end

    // Storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (n_rst && push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        result_valid  = (count_q != '0);
        result_data   = result_valid ? head[31:0]  : '0;
        result_opcode = result_valid ? head[34:32] : '0;
`ifdef OUTENCODE_FP_FLAGS_EN
        result_flags  = result_valid ? head[37:35] : '0;
`endif
        result_count  = count_q;
        overflow_err  = overflow_q;
        out_fifo_hold = (int'(count_q) + $countones(slot_v_q) + int'(HOLD_MARGIN))
                        >= int'(DEPTH);
    end

endmodule

// File: tb/tb_outencode.sv
// Scoreboard bench for outencode: cycle model produces expected entries, monitor checks outputs.
// Build with OUTENCODE_FP_FLAGS_EN defined to also check result_flags.
module tb_outencode;

    localparam int DEPTH       = 8;
    localparam int HOLD_MARGIN = 3;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        add_done, mul_done, sine_done, result_read;
    logic [31:0] add_result, mul_result, sine_result;
    logic        result_valid, out_fifo_hold, overflow_err;
    logic [31:0] result_data;
    logic [2:0]  result_opcode;
    logic [3:0]  result_count;
    logic [2:0]  flags_act;
`ifdef OUTENCODE_FP_FLAGS_EN
    logic [2:0]  result_flags;
    assign flags_act = result_flags;
`else
    assign flags_act = 3'b000;
`endif

    outencode #(.DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN)) dut (
        .clk(clk), .n_rst(n_rst),
        .add_done(add_done), .add_result(add_result),
        .mul_done(mul_done), .mul_result(mul_result),
        .sine_done(sine_done), .sine_result(sine_result),
        .result_read(result_read),
        .result_valid(result_valid), .result_data(result_data),
        .result_opcode(result_opcode), .result_count(result_count),
        .out_fifo_hold(out_fifo_hold), .overflow_err(overflow_err)
`ifdef OUTENCODE_FP_FLAGS_EN
        , .result_flags(result_flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  op;
        logic [2:0]  flags;
    } entry_t;

    entry_t      sb_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          started = 0;
    int          m_cnt;
    bit          m_err;
    bit          m_v[3];
    logic [31:0] m_d[3];

    function automatic logic [2:0] cls(input logic [31:0] x);
`ifdef OUTENCODE_FP_FLAGS_EN
        logic [7:0]  e;
        logic [22:0] m;
        e = x[30:23];
        m = x[22:0];
        return {e == 8'hFF && m != 0, e == 8'hFF && m == 0, e == 0 && m == 0};
`else
        return (x == 32'h0) ? 3'b000 : 3'b000;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-unit pending slot, priority add>mul>sine, queue of depth DEPTH.
    always @(posedge clk) begin
        logic [2:0] opc [3];
        bit         done [3];
        logic [31:0] res [3];
        bit  pop, ok;
        int  w;
        opc[0] = 3'b001; opc[1] = 3'b011; opc[2] = 3'b101;
        done[0] = add_done; done[1] = mul_done; done[2] = sine_done;
        res[0] = add_result; res[1] = mul_result; res[2] = sine_result;
        if (!n_rst) begin
            started = 1;
            m_cnt = 0;
            m_err = 0;
            for (int u = 0; u < 3; u++) begin m_v[u] = 0; m_d[u] = '0; end
            sb_q.delete();
        end else if (started) begin
            pop = result_read && m_cnt > 0;
            ok  = (m_cnt < DEPTH) || pop;
            if (pop) m_cnt--;
            w = -1;
            for (int u = 0; u < 3; u++) if (m_v[u] && w < 0) w = u;
            if (w >= 0 && ok) begin
                sb_q.push_back('{data: m_d[w], op: opc[w], flags: cls(m_d[w])});
                m_cnt++;
                m_v[w] = 0;
            end
            for (int u = 0; u < 3; u++) begin
                if (done[u]) begin
                    if (m_v[u]) m_err = 1;
                    else begin m_v[u] = 1; m_d[u] = res[u]; end
                end
            end
        end
    end

    // Monitor: compares DUT state to the model and retires scoreboard entries on pops.
    always @(negedge clk) begin
        int nslots;
        if (started) begin
            nslots = int'(m_v[0]) + int'(m_v[1]) + int'(m_v[2]);
            check("count", 32'(result_count), 32'(m_cnt));
            check("valid", 32'(result_valid), 32'(m_cnt > 0));
            check("hold", 32'(out_fifo_hold), 32'((DEPTH - m_cnt - nslots) <= HOLD_MARGIN));
            check("overflow", 32'(overflow_err), 32'(m_err));
            if (sb_q.size() > 0) begin
                check("head_data", result_data, sb_q[0].data);
                check("head_opcode", 32'(result_opcode), 32'(sb_q[0].op));
                check("head_flags", 32'(flags_act), 32'(sb_q[0].flags));
            end else begin
                check("empty_data", result_data, 32'h0);
                check("empty_opcode", 32'(result_opcode), 32'h0);
                check("empty_flags", 32'(flags_act), 32'h0);
            end
            if (result_valid && result_read) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: got valid=1 expected empty at %0t", $time);
                end else begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] specials [6];
        specials[0] = 32'h7FC00000; specials[1] = 32'hFF800000; specials[2] = 32'h80000000;
        specials[3] = 32'h00000000; specials[4] = 32'h7F800001; specials[5] = 32'h3F800000;
        if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 0; result_read = 0;
        add_done = 1; mul_done = 1; sine_done = 1;
        add_result = 32'h11111111; mul_result = 32'h22222222; sine_result = 32'h33333333;
        step(2);
        n_rst = 1; add_done = 0; mul_done = 0; sine_done = 0;
        step(2);

        add_done = 1; add_result = 32'h4A1FE982;
        step();
        add_done = 0;
        step(2);
        result_read = 1; step(); result_read = 0;
        step(2);

        add_done = 1; mul_done = 1; sine_done = 1;
        add_result = 32'h3F800000; mul_result = 32'h40700000; sine_result = 32'h3F000000;
        step();
        add_done = 0; mul_done = 0; sine_done = 0;
        step(4);
        result_read = 1; step(3); result_read = 0;
        step(2);

        for (int i = 0; i < 9; i++) begin
            add_done = 1; add_result = 32'h1000 + i;
            step();
        end
        add_done = 0;
        step(2);
        add_done = 1; add_result = 32'hDEADBEEF;
        step();
        add_done = 0;
        step();
        result_read = 1; step(); result_read = 0;
        step(2);

        result_read = 1;
        for (int i = 0; i < 6; i++) begin
            mul_done = 1; mul_result = 32'h2000 + i;
            step();
        end
        mul_done = 0; result_read = 0;
        step(3);
        result_read = 1; step(12); result_read = 0;

        n_rst = 0; step(); n_rst = 1;
        add_result = 32'h7FC00000; add_done = 1; step();
        add_result = 32'hFF800000; step();
        add_result = 32'h80000000; step();
        add_done = 0; step(3);
        result_read = 1; step(4); result_read = 0;

        for (int i = 0; i < 2000; i++) begin
            int rd_bias;
            rd_bias = (i / 250) % 2 == 0 ? 3 : 1;
            add_done = ($urandom_range(2) == 0); add_result = rand_val();
            mul_done = ($urandom_range(2) == 0); mul_result = rand_val();
            sine_done = ($urandom_range(2) == 0); sine_result = rand_val();
            result_read = ($urandom_range(3) >= rd_bias);
            n_rst = ($urandom_range(399) != 0);
            step();
        end
        n_rst = 1; add_done = 0; mul_done = 0; sine_done = 0;
        result_read = 1; step(16); result_read = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/outencode.md
Name: outencode

Overview:
- Result-return path of the FP coprocessor; the opposite end of the input decoder/dispatcher.
- Collects completed results from the add, mul and sine units and tags each with its opcode.
- Queues tagged results in an output FIFO that the CPU drains with a read strobe.
- Drives out_fifo_hold back to the dispatcher so no new operation is issued when the queue cannot absorb its result.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, >=4.
- HOLD_MARGIN, 3, free-entry threshold for out_fifo_hold; 1 <= HOLD_MARGIN < DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- add_done  in  1  one-cycle pulse; add_result valid.
- add_result  in  32  IEEE-754 single result from adder.
- mul_done  in  1  one-cycle pulse; mul_result valid.
- mul_result  in  32  multiplier result.
- sine_done  in  1  one-cycle pulse; sine_result valid.
- sine_result  in  32  sine unit result.
- result_read  in  1  CPU pop request, sampled each rising edge.
- result_valid  out  1  FIFO non-empty.
- result_data  out  32  head entry result (show-ahead).
- result_opcode  out  3  head entry tag: add=3'b001, mul=3'b011, sine=3'b101.
- result_count  out  $clog2(DEPTH)+1  entries held.
- out_fifo_hold  out  1  to dispatcher: do not issue new ops.
- overflow_err  out  1  sticky: a result was lost.

Behaviour:
- Reset: n_rst low at a rising edge clears all state. Resulting outputs: result_valid=0, result_data=0, result_opcode=0, result_count=0, out_fifo_hold=0, overflow_err=0. Reset mid-operation discards all pending and queued results.
- Pending slots: one 32-bit slot plus valid flag per unit.
  - A done pulse loads that unit's slot.
  - If a done arrives while the slot is valid and the slot is not transferred that cycle: new result dropped, overflow_err set (sticky until reset).
  - If the slot transfers and reloads in the same cycle: slot stays valid with the new data; no error.
- Arbiter: each cycle at most one valid slot moves to the FIFO. Fixed priority add > mul > sine. A push is permitted when count < DEPTH, or when a pop happens the same cycle.
- Latency:
  - done at edge N -> slot valid after N.
  - Pushed at edge N+1 if it wins arbitration and space exists -> result_valid high after N+1.
  - Losing slots wait, one cycle each per higher-priority winner.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH.
  - result_data and result_opcode show the head entry whenever result_valid=1; both are 0 when empty.
  - Pop occurs at an edge where result_read=1 and count>0. Holding result_read high pops one entry per cycle.
  - result_read while empty: ignored, no error.
  - Simultaneous push and pop: count unchanged. When full, the popped entry frees space for the push in the same cycle.
- out_fifo_hold: combinational from registered state; equals 1 when (DEPTH - count - valid_slots) <= HOLD_MARGIN.
- Ordering: results from a single unit leave in completion order. Cross-unit order follows the arbitration.

Optional Feature:
- Macro: OUTENCODE_FP_FLAGS_EN.
- Defined: adds output result_flags[2:0] = {is_nan, is_inf, is_zero}.
  - Classified at push from bits [30:23] / [22:0] and stored with the entry.
  - Follows the head entry; 0 when empty or in reset.
- Undefined: port absent, no flag storage, all other behaviour identical.

Test Plan:
- Reset and single add: n_rst=0 for 2 cycles with done pulses asserted -> all outputs 0. Then add_done with add_result=32'h4A1FE982 -> result_valid=1 two edges later, result_data=32'h4A1FE982, result_opcode=3'b001, result_count=1. result_read for 1 cycle -> result_valid=0.
- Simultaneous completion: add_done, mul_done and sine_done in one cycle with values 32'h3F800000 / 32'h40700000 / 32'h3F000000 -> FIFO order add, mul, sine on consecutive edges; opcodes 001, 011, 101.
- Fill and hold (DEPTH=8, HOLD_MARGIN=3), no reads: after 5 entries -> out_fifo_hold=1; after 8 -> result_count=8. Further add_done is held in its slot and not pushed.
- Overflow: FIFO full, add slot valid, second add_done -> overflow_err=1, first result kept. Pop one entry -> held slot pushes, count stays 8. overflow_err stays 1 until reset.
- Concurrent push/pop at full: result_read high while mul_done pulses -> count stays 8, and data order is preserved across the write-pointer wrap.
- OUTENCODE_FP_FLAGS_EN defined: push 32'h7FC00000 -> result_flags=3'b100; 32'hFF800000 -> 3'b010; 32'h80000000 -> 3'b001.
